// File: rtl/linebuffer_pkg.sv
// linebuffer_pkg
// Definitions shared by the feature window loader and the inner-product block:
//   NFEAT  - window length (bias entry, fixed zero entry, then data slots)
//   NSLOT  - number of data slots (entries 2..NFEAT-1)
//   DW     - feature sample width
//   CNT_W  - width of the slot counter (holds 0..NSLOT)
//   lb_state_t - loader FSM states
package linebuffer_pkg;

  localparam int NFEAT = 41;
  localparam int NSLOT = NFEAT - 2;
  localparam int DW    = 32;
  localparam int CNT_W = $clog2(NSLOT + 1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } lb_state_t;

endpackage

// File: rtl/feature_window_loader.sv
// feature_window_loader
// Collects a stream of feature samples into the xarray window consumed by the
// inner-product stage. Entry 0 is the bias, entry 1 is zero, entries 2..NFEAT-1
// hold the most recent NSLOT samples (2 = oldest, NFEAT-1 = newest). Windows
// slide by STRIDE samples; a row boundary (in_last) restarts from empty.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_data    feature sample
//   in_valid   in_data valid
//   in_ready   loader accepts a sample (depends on state only)
//   in_last    sample is the last of its row
//   xarray     window output, NFEAT entries of DW bits
//   win_valid  xarray holds a complete window
//   win_ready  consumer takes the window
//   win_idx    index of the presented window within the row
//   drop_pulse one-cycle pulse when a partial window is discarded
//
// STRIDE must lie in 1..NSLOT; NSLOT gives non-overlapping windows.
module feature_window_loader
  import linebuffer_pkg::*;
#(
  parameter int            STRIDE   = 1,
  parameter logic [DW-1:0] BIAS_VAL = 32'd1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  output logic [DW-1:0] xarray [0:NFEAT-1],
  output logic          win_valid,
  input  logic          win_ready,
  output logic [15:0]   win_idx,
  output logic          drop_pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(NSLOT);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(NSLOT - 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(NSLOT - STRIDE);

  lb_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [15:0]      win_idx_reg, win_idx_next;
  logic             last_reg, last_next;
  logic             drop_reg, drop_next;
  logic             shift_en;
  logic [DW-1:0]    slot_reg [0:NSLOT-1];

  // State register plus counters and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= FILL;
      cnt_reg     <= '0;
      win_idx_reg <= '0;
      last_reg    <= 1'b0;
      drop_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      win_idx_reg <= win_idx_next;
      last_reg    <= last_next;
      drop_reg    <= drop_next;
    end
  end

  // Slot shift register; slot_reg[0] is the oldest sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NSLOT; k++) slot_reg[k] <= '0;
    end else if (shift_en) begin
      for (int k = 0; k < NSLOT - 1; k++) slot_reg[k] <= slot_reg[k + 1];
      slot_reg[NSLOT-1] <= in_data;
    end
  end

  // Next-state logic. in_ready is high exactly in FILL, so in_valid alone
  // qualifies an input handshake there.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    win_idx_next = win_idx_reg;
    last_next    = last_reg;
    drop_next    = 1'b0;
    shift_en     = 1'b0;
    case (state_reg)
      FILL: begin
        if (in_valid) begin
          shift_en = 1'b1;
          if (cnt_reg == CNT_LAST) begin
            // Completing sample: present the window, remember a row end
            // until the window has been taken.
            state_next = FULL;
            cnt_next   = CNT_MAX;
            last_next  = in_last;
          end else if (in_last) begin
            // Row ended before a window completed: discard the partial one.
            cnt_next     = '0;
            win_idx_next = '0;
            drop_next    = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      FULL: begin
        if (win_ready) begin
          state_next = FILL;
          last_next  = 1'b0;
          if (last_reg) begin
            cnt_next     = '0;
            win_idx_next = '0;
          end else begin
            // Keep NSLOT-STRIDE samples so the next window slides by STRIDE.
            cnt_next     = CNT_RELOAD;
            win_idx_next = win_idx_reg + 16'd1;
          end
        end
      end
      default: begin
        state_next = FILL;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    in_ready   = (state_reg == FILL);
    win_valid  = (state_reg == FULL);
    win_idx    = win_idx_reg;
    drop_pulse = drop_reg;
  end

  assign xarray[0] = BIAS_VAL;
  assign xarray[1] = '0;

  for (genvar gi = 0; gi < NSLOT; gi++) begin : g_xarray
    assign xarray[gi + 2] = slot_reg[gi];
  end

endmodule

// File: doc/feature_window_loader.md
# feature_window_loader

Producer side of the logistic-regression inner-product stage: accepts a stream of 32-bit feature samples with a valid/ready handshake and assembles them into the 41-entry `xarray` window that the inner-product combinational block consumes. Entry 0 is the bias input and entry 1 is a fixed zero; entries 2..40 hold the 39 most recent samples. Complete windows are presented with a valid/ready handshake, and consecutive windows slide by a programmable stride. On each row boundary the window restarts from empty.

## Interface
- `NFEAT`, 41: window length; it must match the inner-product block.
- `NSLOT`, `NFEAT-2` (39): number of data slots, entries 2..NFEAT-1.
- `STRIDE`, 1: new samples required between consecutive windows. Legal range is 1..NSLOT; NSLOT gives non-overlapping windows.
- `BIAS_VAL`, 32'd1: constant driven on `xarray[0]`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_data`  in  32  feature sample.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader can accept a sample.
- `in_last`  in  1  sample is the last of its row; qualified by the input handshake.
- `xarray`  out  32 x [0:NFEAT-1]  feature window, unpacked array.
- `win_valid`  out  1  `xarray` holds a complete window.
- `win_ready`  in  1  consumer takes the window.
- `win_idx`  out  16  index of the presented window within the current row.
- `drop_pulse`  out  1  one-cycle pulse when a partial window is discarded at `in_last`.

## Operation
- **States:** FILL and FULL. Slot counter `cnt` has range 0..NSLOT.
- **FILL:**
  - `in_ready`=1 and `win_valid`=0.
  - An input handshake (`in_valid`&&`in_ready`) shifts the slots down by one: `xarray[k]` takes `xarray[k+1]` for k=2..NFEAT-2, and `xarray[NFEAT-1]` takes `in_data`. Slot 2 is the oldest sample and slot NFEAT-1 the newest.
  - The handshake also increments `cnt`.
- **FILL -> FULL:** occurs on a handshake that brings `cnt` to NSLOT.
- **FULL:**
  - `in_ready`=0 and `win_valid`=1.
  - `xarray` is frozen; no slot or counter changes until `win_ready`.
- **FULL -> FILL:** on `win_valid`&&`win_ready`.
  - `cnt` becomes NSLOT-STRIDE and `win_idx` increments.
  - If the completing sample carried `in_last`, `cnt` and `win_idx` become 0 instead.
- **`in_last` on a sample that does not complete a window:**
  - The sample is shifted in, then `cnt` becomes 0 and `win_idx` becomes 0.
  - `drop_pulse`=1 for the next cycle.
  - Slot contents are not cleared; stale data is overwritten before the next window completes.
- **`in_last` on a completing sample:** the window is still presented normally. The flag is latched until that window's handshake.
- **Fixed entries:** `xarray[0]`=BIAS_VAL and `xarray[1]`=0 at all times.
- **Data path:** samples are passed unmodified, with no width change or sign handling.
- **Counter wrap:** `win_idx` wraps from 16'hFFFF to 0.

## Timing
- **Reset values:**
  - State FILL, `cnt`=0, `win_idx`=0.
  - `xarray[2..NFEAT-1]`=0.
  - `win_valid`=0, `drop_pulse`=0, latched last flag 0.
  - `in_ready` is 1 while in FILL, including during reset. Input handshakes are ignored while `rst` is high.
- **Reset mid-operation:** `rst` asserted at any time forces the reset values immediately (asynchronously). A window pending in FULL is lost without a handshake.
- **Window latency:** `win_valid` rises in the cycle after the edge that accepts the completing sample. `xarray` is stable from that cycle until the `win_ready` edge.
- **`win_valid` hold:** `win_valid` stays high until it is consumed, regardless of `in_valid`.
- **Throughput:** steady-state minimum is STRIDE+1 cycles per window. The FULL cycle is never overlapped with input acceptance.
- **Handshakes:** `in_ready` does not depend on `in_valid` or `win_ready` within a cycle; it is a function of state only.
- **`drop_pulse`:** registered, high for exactly one cycle.

## Structure
- **Shared package `linebuffer_pkg`:** `NFEAT`, `NSLOT`, data width 32, and the FILL/FULL state enum. The inner-product block and this loader import the same `NFEAT`.
- **Sub-modules:** none. The shift array, counter and two-state FSM remain in a single module of roughly 150-250 lines.

## Test plan
- **Fill and present:** after reset, send 39 samples 1..39 with no `in_last`.
  - Required: `win_valid` rises one cycle after sample 39; `xarray[2]`=1, `xarray[40]`=39, `xarray[0]`=1, `xarray[1]`=0; `win_idx`=0.
- **Backpressure:** hold `win_ready`=0 for 10 cycles while `in_valid`=1.
  - Required: `in_ready`=0 throughout, `xarray` unchanged, no samples lost; the next accepted sample is the one that was pending.
- **Stride:**
  - STRIDE=1: sample 40 after the handshake gives `xarray[2]`=2, `xarray[40]`=40, `win_idx`=1.
  - STRIDE=39: 39 new samples are required before the next window.
- **Partial row:** send 20 samples with `in_last` on the 20th.
  - Required: `drop_pulse` high for one cycle, no `win_valid`; the next 39 samples form a window with `win_idx`=0.
- **Last on the completing sample:** `in_last` set on sample 39.
  - Required: window presented; after the handshake `cnt`=0 and 39 further samples are needed.
- **Reset mid-window:** assert `rst` while in FULL.
  - Required: `win_valid` drops without a clock edge; all reset values hold; normal fill resumes after release.
